// File: rtl/serial_alu.sv
// serial_alu: bit-serial ALU (and / add / or / xor), one result bit per clock,
// LSB first. A completed operation is flagged by a one-cycle valid pulse.
// Optional build macro SERIAL_ALU_FLAGS_EN adds registered zero and ovf flags.
module serial_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic             cin,
    input  logic             s1,
    input  logic             s0,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] result,
    output logic             cout
`ifdef SERIAL_ALU_FLAGS_EN
    ,
    output logic             zero,
    output logic             ovf
`endif
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_OR  = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [1:0]         op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               cout_q, cout_d;
`ifdef SERIAL_ALU_FLAGS_EN
    logic               zero_q, zero_d;
    logic               ovf_q, ovf_d;
`endif

    logic               bit_a;
    logic               bit_b;
    logic               bit_r;
    logic               carry_nx;

    function automatic logic fa_sum(input logic a, input logic b, input logic c);
        return a ^ b ^ c;
    endfunction

    function automatic logic fa_carry(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Next-state logic: accept a request in IDLE, shift one bit per RUN cycle, pulse DONE.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        result_d = result_q;
        cout_d   = cout_q;
`ifdef SERIAL_ALU_FLAGS_EN
        zero_d   = zero_q;
        ovf_d    = ovf_q;
`endif
        bit_a    = a_q[cnt_q];
        bit_b    = b_q[cnt_q];
        carry_nx = fa_carry(bit_a, bit_b, carry_q);
        case (op_q)
            OP_ADD:  bit_r = fa_sum(bit_a, bit_b, carry_q);
            OP_OR:   bit_r = bit_a | bit_b;
            OP_XOR:  bit_r = bit_a ^ bit_b;
            default: bit_r = bit_a & bit_b;
        endcase

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = inA;
                    b_d     = inB;
                    op_d    = {s1, s0};
                    cnt_d   = '0;
                    // Only add ever sees a carry; logic ops keep it parked at 0.
                    carry_d = ({s1, s0} == OP_ADD) ? cin : 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                result_d[cnt_q] = bit_r;
                carry_d = (op_q == OP_ADD) ? carry_nx : 1'b0;
                if (cnt_q == LAST_BIT) begin
                    state_d = DONE;
                    cout_d  = (op_q == OP_ADD) ? carry_nx : 1'b0;
`ifdef SERIAL_ALU_FLAGS_EN
                    zero_d  = (result_d == '0);
                    // Signed overflow: carry into the MSB differs from carry out of it.
                    ovf_d   = (op_q == OP_ADD) ? (carry_q ^ carry_nx) : 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and result registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
`ifdef SERIAL_ALU_FLAGS_EN
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            cout_q   <= cout_d;
`ifdef SERIAL_ALU_FLAGS_EN
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    // Latched operands and select; only meaningful while RUN, so no reset needed.
    always_ff @(posedge clk) begin
        a_q  <= a_d;
        b_q  <= b_d;
        op_q <= op_d;
    end

    assign busy   = (state_q != IDLE);
    assign valid  = (state_q == DONE);
    assign result = result_q;
    assign cout   = cout_q;
`ifdef SERIAL_ALU_FLAGS_EN
    assign zero   = zero_q;
    assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_alu.sv
// Testbench for serial_alu: stimulus pushes expected results into a scoreboard,
// a negedge monitor checks busy/valid timing, result data and result holding.
module tb_serial_alu;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] inA;
    logic [W-1:0] inB;
    logic         cin;
    logic         s1;
    logic         s0;
    logic         busy;
    logic         valid;
    logic [W-1:0] result;
    logic         cout;
`ifdef SERIAL_ALU_FLAGS_EN
    logic         zero;
    logic         ovf;
`endif

    serial_alu #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .inA    (inA),
        .inB    (inB),
        .cin    (cin),
        .s1     (s1),
        .s0     (s0),
        .busy   (busy),
        .valid  (valid),
        .result (result),
        .cout   (cout)
`ifdef SERIAL_ALU_FLAGS_EN
        ,
        .zero   (zero),
        .ovf    (ovf)
`endif
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    logic rst_d = 1'b0;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_d <= reset;
    end

    typedef struct {
        int           acc;   // clock edge number that accepts the start
        logic [W-1:0] res;
        logic         co;
        logic         zf;
        logic         of;
    } exp_t;

    exp_t scb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on the whole operands.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic c, input logic [1:0] op, input int acc);
        exp_t m;
        int   ua;
        int   ub;
        int   sa;
        int   sb;
        int   s;
        ua = int'(a);
        ub = int'(b);
        sa = (ua >= 2**(W-1)) ? ua - 2**W : ua;
        sb = (ub >= 2**(W-1)) ? ub - 2**W : ub;
        m.acc = acc;
        m.co  = 1'b0;
        m.of  = 1'b0;
        case (op)
            2'b00: m.res = a & b;
            2'b01: begin
                s     = ua + ub + (c ? 1 : 0);
                m.res = W'(s % (2**W));
                m.co  = (s >= 2**W);
                s     = sa + sb + (c ? 1 : 0);
                m.of  = (s > 2**(W-1) - 1) || (s < -(2**(W-1)));
            end
            2'b10: m.res = a | b;
            default: m.res = a ^ b;
        endcase
        m.zf = (m.res == '0);
        return m;
    endfunction

    // Monitor: expected busy/valid derived from the head of the scoreboard.
    logic [W-1:0] last_res = '0;
    logic         last_co  = 1'b0;
    logic         last_zf  = 1'b0;
    logic         last_of  = 1'b0;
    always @(negedge clk) begin
        logic exp_busy;
        logic exp_valid;
        if (cyc > 0) begin
            exp_busy  = 1'b0;
            exp_valid = 1'b0;
            if (rst_d) begin
                while (scb.size() > 0 && scb[0].acc <= cyc) scb.delete(0);
                last_res = '0;
                last_co  = 1'b0;
                last_zf  = 1'b0;
                last_of  = 1'b0;
                chk("rst_busy", 32'(busy), 32'(0));
                chk("rst_valid", 32'(valid), 32'(0));
                chk("rst_result", 32'(result), 32'(0));
                chk("rst_cout", 32'(cout), 32'(0));
`ifdef SERIAL_ALU_FLAGS_EN
                chk("rst_zero", 32'(zero), 32'(0));
                chk("rst_ovf", 32'(ovf), 32'(0));
`endif
            end else begin
                if (scb.size() > 0 && cyc >= scb[0].acc && cyc <= scb[0].acc + W) begin
                    exp_busy  = 1'b1;
                    exp_valid = (cyc == scb[0].acc + W);
                end
                chk("busy", 32'(busy), 32'(exp_busy));
                chk("valid", 32'(valid), 32'(exp_valid));
                if (exp_valid) begin
                    chk("result", 32'(result), 32'(scb[0].res));
                    chk("cout", 32'(cout), 32'(scb[0].co));
`ifdef SERIAL_ALU_FLAGS_EN
                    chk("zero", 32'(zero), 32'(scb[0].zf));
                    chk("ovf", 32'(ovf), 32'(scb[0].of));
`endif
                    last_res = scb[0].res;
                    last_co  = scb[0].co;
                    last_zf  = scb[0].zf;
                    last_of  = scb[0].of;
                    scb.delete(0);
                end else if (!exp_busy) begin
                    chk("hold_result", 32'(result), 32'(last_res));
                    chk("hold_cout", 32'(cout), 32'(last_co));
`ifdef SERIAL_ALU_FLAGS_EN
                    chk("hold_zero", 32'(zero), 32'(last_zf));
                    chk("hold_ovf", 32'(ovf), 32'(last_of));
`endif
                end
            end
        end
    end

    task automatic scramble();
        inA = W'($urandom);
        inB = W'($urandom);
        cin = 1'($urandom);
        s1  = 1'($urandom);
        s0  = 1'($urandom);
    endtask

    // Issue one operation from a negedge. early: called in the DONE cycle, so the
    // start is held until the following IDLE cycle. Returns at the negedge of the
    // DONE cycle (or one cycle after a mid-run reset).
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input logic [1:0] op, input bit early, input bit poke,
                          input bit rst_mid);
        int acc;
        inA   = a;
        inB   = b;
        cin   = c;
        s1    = op[1];
        s0    = op[0];
        start = 1'b1;
        acc   = cyc + (early ? 2 : 1);
        scb.push_back(model(a, b, c, op, acc));
        repeat (early ? 2 : 1) @(posedge clk);
        #1;
        start = 1'b0;
        scramble();
        if (poke) begin
            while (cyc != acc + 2) @(negedge clk);
            start = 1'b1;
            scramble();
            @(posedge clk);
            #1;
            start = 1'b0;
            scramble();
        end
        if (rst_mid) begin
            while (cyc != acc + 3) @(negedge clk);
            reset = 1'b1;
            @(posedge clk);
            #1;
            reset = 1'b0;
            @(negedge clk);
        end else begin
            while (cyc != acc + W) @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        inA   = '0;
        inB   = '0;
        cin   = 1'b0;
        s1    = 1'b0;
        s0    = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        run_op(8'hF0, 8'h0F, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        run_op(8'hFF, 8'h01, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        run_op(8'h7F, 8'h00, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        run_op(8'hAA, 8'hFF, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
        run_op(8'hAA, 8'hFF, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        run_op(8'h3C, 8'h5A, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        run_op(8'hC3, 8'h81, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        run_op(8'h12, 8'h34, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            bit early;
            early = 1'($urandom_range(0, 1));
            if (!early) @(negedge clk);
            run_op(W'($urandom), W'($urandom), 1'($urandom), 2'($urandom), early,
                   ($urandom_range(0, 4) == 0), 1'b0);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(scb.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
